// File: rtl/sec_pkg.sv
// ============================================================================
//  Module      : sec_pkg
//  Description : Shared types and constants for the keypad code lock:
//                FSM state encoding and the 7-segment digit table.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sec_pkg;

  // Lock controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  // All segments off (active-low display)
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segment patterns for digits 0..9, bit6=a .. bit0=g
  localparam logic [6:0] SEG_LUT [10] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100   // 9
  };

  // Digit to segment pattern; anything outside 0..9 shows blank
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    if (digit <= 4'd9) begin
      return SEG_LUT[digit];
    end
    return SEG_BLANK;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_priority_encoder.sv
// ============================================================================
//  Module      : key_priority_encoder
//  Description : Combinational priority encoder for the keypad. Reports
//                whether any key is down and the index of the highest key.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_priority_encoder #(
  parameter int NUM_KEYS = 4,
  parameter int KEY_W    = $clog2(NUM_KEYS)
) (
  input  logic [NUM_KEYS-1:0] key_in,
  output logic                valid,
  output logic [KEY_W-1:0]    digit
);

  // Highest set bit wins: later loop iterations override lower indices
  always_comb begin
    valid = |key_in;
    digit = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_in[i]) begin
        digit = KEY_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/keypad_code_lock.sv
// ============================================================================
//  Module      : keypad_code_lock
//  Description : Keypad security lock. Edge-detects key presses, checks a
//                CODE_LEN-digit sequence, counts failed attempts, locks out
//                after MAX_ATTEMPTS failures and holds the door open for
//                UNLOCK_CYCLES. Shows the last pressed digit on a 7-seg.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_code_lock
  import sec_pkg::*;
#(
  parameter int                                   NUM_KEYS       = 4,
  parameter int                                   CODE_LEN       = 2,
  parameter logic [CODE_LEN*$clog2(NUM_KEYS)-1:0] CODE           = 4'b1110,
  parameter int                                   MAX_ATTEMPTS   = 3,
  parameter int                                   LOCKOUT_CYCLES = 16,
  parameter int                                   UNLOCK_CYCLES  = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic                unlocked,
  output logic                alarm,
  output logic                locked_out,
  output logic [3:0]          attempts_left,
  output logic [3:0]          digit_cnt,
  output logic [6:0]          seg_out
);

  localparam int KEY_W     = $clog2(NUM_KEYS);
  localparam int TIMER_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W     = $clog2(TIMER_MAX + 1);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_any_prev;
  logic               r_mismatch;
  logic [3:0]         r_digit_cnt;
  logic [3:0]         r_attempts;
  logic [TMR_W-1:0]   r_timer;
  logic [6:0]         r_seg;

  logic               w_key_valid;
  logic [KEY_W-1:0]   w_digit;
  logic [KEY_W-1:0]   w_code_digit;
  logic               w_press;
  logic               w_accept;
  logic               w_last;
  logic               w_mism;
  logic               w_timer_done;

  key_priority_encoder #(
    .NUM_KEYS (NUM_KEYS),
    .KEY_W    (KEY_W)
  ) u_enc (
    .key_in (key_in),
    .valid  (w_key_valid),
    .digit  (w_digit)
  );

  // A press is the rising edge of "any key down"; added keys while held are not presses
  assign w_press      = w_key_valid && !r_any_prev;
  assign w_accept     = w_press && ((r_state == IDLE) || (r_state == ENTRY));
  assign w_last       = w_accept && (r_digit_cnt == 4'(CODE_LEN - 1));
  assign w_mism       = ((r_state == ENTRY) && r_mismatch) || (w_digit != w_code_digit);
  assign w_timer_done = (r_timer == TMR_W'(1));

  // Select the expected code digit for the position being entered
  always_comb begin
    w_code_digit = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (r_digit_cnt == 4'(i)) begin
        w_code_digit = CODE[i*KEY_W +: KEY_W];
      end
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; the final digit decides the outcome directly from the press cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, ENTRY: begin
        if (w_last) begin
          if (!w_mism) begin
            w_next_state = OPEN;
          end else if (r_attempts > 4'd1) begin
            w_next_state = IDLE;
          end else begin
            w_next_state = LOCKOUT;
          end
        end else if (w_accept) begin
          w_next_state = ENTRY;
        end
      end
      OPEN, LOCKOUT: begin
        if (w_timer_done) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State-decoded outputs; the timer is still at its load value only in the first LOCKOUT cycle
  always_comb begin
    unlocked   = (r_state == OPEN);
    locked_out = (r_state == LOCKOUT);
    alarm      = (r_state == LOCKOUT) && (r_timer == TMR_W'(LOCKOUT_CYCLES));
  end

  // Datapath: key history, display, digit counter, mismatch flag, attempts and shared timer
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_any_prev  <= 1'b0;
      r_seg       <= SEG_BLANK;
      r_digit_cnt <= 4'd0;
      r_mismatch  <= 1'b0;
      r_attempts  <= 4'(MAX_ATTEMPTS);
      r_timer     <= '0;
    end else begin
      r_any_prev <= w_key_valid;
      if (w_press) begin
        r_seg <= seg_encode(4'(w_digit));
      end
      case (r_state)
        IDLE, ENTRY: begin
          if (w_last) begin
            r_digit_cnt <= 4'd0;
            r_mismatch  <= 1'b0;
            if (!w_mism) begin
              r_attempts <= 4'(MAX_ATTEMPTS);
              r_timer    <= TMR_W'(UNLOCK_CYCLES);
            end else if (r_attempts > 4'd1) begin
              r_attempts <= r_attempts - 4'd1;
            end else begin
              r_attempts <= 4'd0;
              r_timer    <= TMR_W'(LOCKOUT_CYCLES);
            end
          end else if (w_accept) begin
            r_digit_cnt <= r_digit_cnt + 4'd1;
            r_mismatch  <= w_mism;
          end
        end
        OPEN: begin
          r_timer <= r_timer - TMR_W'(1);
        end
        LOCKOUT: begin
          r_timer <= r_timer - TMR_W'(1);
          if (w_timer_done) begin
            r_attempts <= 4'(MAX_ATTEMPTS);
          end
        end
        default: ;
      endcase
    end
  end

  assign attempts_left = r_attempts;
  assign digit_cnt     = r_digit_cnt;
  assign seg_out       = r_seg;

endmodule

`default_nettype wire
